// File: rtl/clk_wiz.sv
// -----------------------------------------------------------------------------
// clk_wiz -- clock/strobe generator driven by a single 100 MHz system clock.
//
// Every output comes straight from a flip-flop clocked on clk_in, so the
// derived "clocks" are glitch-free, fixed-ratio divisions of clk_in.
//
// Parameters:
//   DIV60_TERM  - terminal count of the frame half-period counter (~60 Hz)
//   MIC_TERM    - terminal count of the microphone half-period counter
//   LOCK_CYCLES - clk_in edges after reset release before locked asserts
//
// Ports:
//   clk_in  - system clock, all logic on its rising edge
//   reset   - asynchronous, active-high reset
//   clk_25  - clk_in/4 pixel clock, 50% duty
//   clk_60  - frame clock, period 2*(DIV60_TERM+1) clk_in cycles
//   tick_60 - one-cycle pulse in the cycle clk_60 goes 0->1
//   mic_clk - PDM microphone clock, period 2*(MIC_TERM+1) clk_in cycles
//   locked  - status flag, high LOCK_CYCLES edges after reset release
//
// Configuration macro:
//   CLK_WIZ_MIC_CLK_EN - when defined the microphone divider is built;
//                        otherwise mic_clk is tied low.
// -----------------------------------------------------------------------------
module clk_wiz #(
   parameter int unsigned DIV60_TERM  = 833334,
   parameter int unsigned MIC_TERM    = 17,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic clk_in,
   input  logic reset,
   output logic clk_25,
   output logic clk_60,
   output logic tick_60,
   output logic mic_clk,
   output logic locked
);

   // Half-period counters are 20 bits; larger terminal counts are not legal.
   localparam logic [19:0] DIV60_TERM_C = 20'(DIV60_TERM);
   localparam int unsigned LOCK_W       = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
   localparam logic [LOCK_W-1:0] LOCK_TERM_C = LOCK_W'(LOCK_CYCLES);
   localparam logic [LOCK_W-1:0] LOCK_ONE_C  = LOCK_W'(1);

   logic [1:0]        div4_q,      div4_d;
   logic [19:0]       frame_cnt_q, frame_cnt_d;
   logic              clk_60_q,    clk_60_d;
   logic              tick_60_q,   tick_60_d;
   logic [LOCK_W-1:0] lock_cnt_q,  lock_cnt_d;
   logic              locked_q,    locked_d;

   // NOTE: every next-state signal is assigned a default at the top of the
   // always_comb so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      div4_d      = div4_q + 2'd1;
      frame_cnt_d = frame_cnt_q + 20'd1;
      clk_60_d    = clk_60_q;
      lock_cnt_d  = lock_cnt_q;

      // ">=" rather than "==" so a counter beyond its terminal still wraps.
      if (frame_cnt_q >= DIV60_TERM_C) begin
         frame_cnt_d = '0;
         clk_60_d    = ~clk_60_q;
      end

      // Registered strobe lands in the same cycle clk_60_q becomes 1.
      tick_60_d = (frame_cnt_q >= DIV60_TERM_C) && !clk_60_q;

      if (lock_cnt_q < LOCK_TERM_C) begin
         lock_cnt_d = lock_cnt_q + LOCK_ONE_C;
      end
      // Computed from the next count so locked rises on edge LOCK_CYCLES.
      locked_d = (lock_cnt_d == LOCK_TERM_C);
   end

   // Counters preload their terminal during reset so the first edge after
   // release toggles the divided clocks high.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         div4_q      <= 2'd0;
         frame_cnt_q <= DIV60_TERM_C;
         clk_60_q    <= 1'b0;
         tick_60_q   <= 1'b0;
         lock_cnt_q  <= '0;
         locked_q    <= 1'b0;
      end else begin
         div4_q      <= div4_d;
         frame_cnt_q <= frame_cnt_d;
         clk_60_q    <= clk_60_d;
         tick_60_q   <= tick_60_d;
         lock_cnt_q  <= lock_cnt_d;
         locked_q    <= locked_d;
      end
   end

   assign clk_25  = div4_q[1];
   assign clk_60  = clk_60_q;
   assign tick_60 = tick_60_q;
   assign locked  = locked_q;

`ifdef CLK_WIZ_MIC_CLK_EN
   localparam logic [19:0] MIC_TERM_C = 20'(MIC_TERM);

   logic [19:0] mic_cnt_q, mic_cnt_d;
   logic        mic_clk_q, mic_clk_d;

   always_comb begin
      mic_cnt_d = mic_cnt_q + 20'd1;
      mic_clk_d = mic_clk_q;
      if (mic_cnt_q >= MIC_TERM_C) begin
         mic_cnt_d = '0;
         mic_clk_d = ~mic_clk_q;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         mic_cnt_q <= MIC_TERM_C;
         mic_clk_q <= 1'b0;
      end else begin
         mic_cnt_q <= mic_cnt_d;
         mic_clk_q <= mic_clk_d;
      end
   end

   assign mic_clk = mic_clk_q;
`else
   assign mic_clk = 1'b0;
`endif

endmodule

// File: tb/tb_clk_wiz.sv
// -----------------------------------------------------------------------------
// tb_clk_wiz -- directed self-checking bench for clk_wiz.
// Runs with DIV60_TERM=9, MIC_TERM=17, LOCK_CYCLES=16. Edge k means the k-th
// rising clk_in edge after reset is released; outputs are sampled on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_clk_wiz;

   localparam int unsigned DIV60 = 9;
   localparam int unsigned MIC   = 17;
   localparam int unsigned LOCK  = 16;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   logic clk_25, clk_60, tick_60, mic_clk, locked;

   int vectors = 0;
   int errors  = 0;

   always #5 clk_in = ~clk_in;

   clk_wiz #(
      .DIV60_TERM (DIV60),
      .MIC_TERM   (MIC),
      .LOCK_CYCLES(LOCK)
   ) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .clk_25 (clk_25),
      .clk_60 (clk_60),
      .tick_60(tick_60),
      .mic_clk(mic_clk),
      .locked (locked)
   );

   // Hold reset for a few edges and release it on a falling edge, so the
   // next rising edge is edge 1.
   task automatic apply_reset();
      @(negedge clk_in);
      reset = 1'b1;
      repeat (3) @(negedge clk_in);
      reset = 1'b0;
   endtask

   // Advance one rising edge and park on the following falling edge.
   task automatic step();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk_in);
      vectors++;
      if (clk_25 !== 1'b0) begin errors++; $display("FAIL reset_clk_25: got %b expected 0", clk_25); end
      vectors++;
      if (clk_60 !== 1'b0) begin errors++; $display("FAIL reset_clk_60: got %b expected 0", clk_60); end
      vectors++;
      if (tick_60 !== 1'b0) begin errors++; $display("FAIL reset_tick_60: got %b expected 0", tick_60); end
      vectors++;
      if (mic_clk !== 1'b0) begin errors++; $display("FAIL reset_mic_clk: got %b expected 0", mic_clk); end
      vectors++;
      if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
   endtask

   task automatic test_clk_25();
      logic exp;
      apply_reset();
      for (int k = 1; k <= 16; k++) begin
         step();
         // Pattern from edge 0: 0,0,1,1 -> high on edges 2,3,6,7,...
         exp = ((k % 4) >= 2);
         vectors++;
         if (clk_25 !== exp) begin
            errors++;
            $display("FAIL clk_25 edge %0d: got %b expected %b", k, clk_25, exp);
         end
      end
   endtask

   task automatic test_clk_60();
      logic exp_clk, exp_tick;
      apply_reset();
      for (int k = 1; k <= 42; k++) begin
         step();
         // High on edges 1-10, low 11-20, high 21-30, low 31-40, high 41..
         exp_clk  = (((k - 1) / 10) % 2) == 0;
         exp_tick = (k == 1) || (k == 21) || (k == 41);
         vectors++;
         if (clk_60 !== exp_clk) begin
            errors++;
            $display("FAIL clk_60 edge %0d: got %b expected %b", k, clk_60, exp_clk);
         end
         vectors++;
         if (tick_60 !== exp_tick) begin
            errors++;
            $display("FAIL tick_60 edge %0d: got %b expected %b", k, tick_60, exp_tick);
         end
      end
   endtask

   task automatic test_locked();
      logic exp;
      apply_reset();
      for (int k = 1; k <= 20; k++) begin
         step();
         exp = (k >= 16);
         vectors++;
         if (locked !== exp) begin
            errors++;
            $display("FAIL locked edge %0d: got %b expected %b", k, locked, exp);
         end
      end
      // Mid-run reset pulse away from any clock edge: locked drops at once.
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL locked_async_drop: got %b expected 0", locked);
      end
      @(negedge clk_in);
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp = (k >= 16);
         vectors++;
         if (locked !== exp) begin
            errors++;
            $display("FAIL locked_relock edge %0d: got %b expected %b", k, locked, exp);
         end
      end
   endtask

   task automatic test_reset_mid_period();
      logic exp_clk, exp_tick;
      apply_reset();
      // After edge 6 the frame counter holds 5; clk_60 and clk_25 are high.
      repeat (6) step();
      vectors++;
      if (clk_60 !== 1'b1) begin errors++; $display("FAIL mid_pre_clk_60: got %b expected 1", clk_60); end
      vectors++;
      if (clk_25 !== 1'b1) begin errors++; $display("FAIL mid_pre_clk_25: got %b expected 1", clk_25); end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (clk_25 !== 1'b0) begin errors++; $display("FAIL mid_clk_25: got %b expected 0", clk_25); end
      vectors++;
      if (clk_60 !== 1'b0) begin errors++; $display("FAIL mid_clk_60: got %b expected 0", clk_60); end
      vectors++;
      if (tick_60 !== 1'b0) begin errors++; $display("FAIL mid_tick_60: got %b expected 0", tick_60); end
      vectors++;
      if (mic_clk !== 1'b0) begin errors++; $display("FAIL mid_mic_clk: got %b expected 0", mic_clk); end
      vectors++;
      if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked: got %b expected 0", locked); end
      @(negedge clk_in);
      reset = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         step();
         exp_clk  = (((k - 1) / 10) % 2) == 0;
         exp_tick = (k == 1) || (k == 21);
         vectors++;
         if (clk_60 !== exp_clk) begin
            errors++;
            $display("FAIL mid_rerun_clk_60 edge %0d: got %b expected %b", k, clk_60, exp_clk);
         end
         vectors++;
         if (tick_60 !== exp_tick) begin
            errors++;
            $display("FAIL mid_rerun_tick_60 edge %0d: got %b expected %b", k, tick_60, exp_tick);
         end
      end
   endtask

`ifdef CLK_WIZ_MIC_CLK_EN
   task automatic test_mic_clk();
      logic exp;
      apply_reset();
      for (int k = 1; k <= 40; k++) begin
         step();
         // High on edges 1-18, low 19-36, high again from 37.
         exp = (((k - 1) / 18) % 2) == 0;
         vectors++;
         if (mic_clk !== exp) begin
            errors++;
            $display("FAIL mic_clk edge %0d: got %b expected %b", k, mic_clk, exp);
         end
      end
   endtask
`else
   task automatic test_mic_clk();
      int bad;
      logic exp25;
      bad = 0;
      apply_reset();
      for (int k = 1; k <= 1000; k++) begin
         step();
         if (mic_clk !== 1'b0) bad++;
         exp25 = ((k % 4) >= 2);
         if (k <= 16) begin
            vectors++;
            if (clk_25 !== exp25) begin
               errors++;
               $display("FAIL nomic_clk_25 edge %0d: got %b expected %b", k, clk_25, exp25);
            end
         end
      end
      vectors++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL mic_clk_tied: got %0d nonzero samples expected 0", bad);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clk_25();
      test_clk_60();
      test_locked();
      test_reset_mid_period();
      test_mic_clk();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
